// File: rtl/nn_backprop_update.sv
// Backward pass: per-sample error from ycap/label, per-feature gradient MAC over the batch,
// then a saturating weight write-back. One gradient step per start pulse; start is ignored while busy.
module nn_backprop_update #(
    parameter int N_IN     = 784,
    parameter int N_S      = 40,
    parameter int LR_SHIFT = 4,
    parameter int AW       = 10,
    parameter int CW       = 6,
    parameter int XAW      = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  y_addr,
    input  logic [9:0]     ycap_rdata,
    input  logic           label_rdata,
    output logic [XAW-1:0] x_addr,
    input  logic [16:0]    x_rdata,
    output logic [AW-1:0]  w_addr,
    input  logic [15:0]    w_rdata,
    output logic           w_we,
    output logic [15:0]    w_wdata,
    output logic [AW:0]    sat_count
);

    typedef enum logic [2:0] {IDLE, ERR, GRAD, DRAIN, UPD, FIN} state_t;

    localparam int IW   = (N_S > 1) ? $clog2(N_S) : 1;
    localparam int CNTW = $clog2(N_S + 1);
    localparam logic [CNTW-1:0] CNT_PRE  = CNTW'(N_S - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N_S);
    localparam logic [AW-1:0]   I_LAST   = AW'(N_IN - 1);
    localparam int SH = 8 + LR_SHIFT;

    state_t state, state_nxt;

    logic [CNTW-1:0]    cnt;
    logic signed [9:0]  err_mem [N_S];
    logic               ycap_vld;
    logic [IW-1:0]      ycap_idx;
    logic               mac_vld;
    logic [IW-1:0]      mac_idx;
    logic               w_cap;
    logic signed [15:0] w_old;
    logic signed [15:0] w_cur;
    logic signed [39:0] acc;
    logic signed [39:0] acc_sum;
    logic signed [39:0] delta;
    logic signed [26:0] prod;
    logic signed [9:0]  err_val;
    logic signed [40:0] w_new;
    logic signed [15:0] w_sat;
    logic               w_clamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ERR;
            end
            ERR: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = GRAD;
            end
            GRAD: begin
                busy = 1'b1;
                if (cnt == CNT_PRE) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = UPD;
            end
            UPD: begin
                busy      = 1'b1;
                state_nxt = (w_addr == I_LAST) ? FIN : GRAD;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath runs one cycle behind the addresses because every RAM read has one cycle of latency.
    always_comb begin
        err_val = $signed(ycap_rdata) - (label_rdata ? 10'sd256 : 10'sd0);
        prod    = 27'($signed(x_rdata)) * 27'(err_mem[mac_idx]);
        acc_sum = acc + 40'(prod);
        delta   = acc_sum >>> SH;
        w_cur   = w_cap ? $signed(w_rdata) : w_old;
        w_new   = 41'(w_cur) - 41'(delta);
        w_clamp = 1'b0;
        w_sat   = w_new[15:0];
        if (w_new > 41'sd32767) begin
            w_sat   = 16'sh7fff;
            w_clamp = 1'b1;
        end else if (w_new < -41'sd32768) begin
            w_sat   = 16'sh8000;
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ycap_vld  <= 1'b0;
            ycap_idx  <= '0;
            mac_vld   <= 1'b0;
            mac_idx   <= '0;
            w_cap     <= 1'b0;
            w_old     <= '0;
            acc       <= '0;
            y_addr    <= '0;
            x_addr    <= '0;
            w_addr    <= '0;
            w_we      <= 1'b0;
            w_wdata   <= '0;
            sat_count <= '0;
            for (int k = 0; k < N_S; k++) err_mem[k] <= '0;
        end else begin
            cnt      <= (state_nxt != state) ? '0 : cnt + CNTW'(1);
            ycap_vld <= (state == ERR) && (cnt < CNT_LAST);
            ycap_idx <= cnt[IW-1:0];
            mac_vld  <= (state == GRAD);
            mac_idx  <= cnt[IW-1:0];
            w_cap    <= (state == GRAD) && (cnt == '0);
            w_we     <= (state == DRAIN);

            if (ycap_vld) err_mem[ycap_idx] <= err_val;
            if (w_cap) w_old <= $signed(w_rdata);

            if ((state == GRAD) && (cnt == '0)) begin
                acc <= '0;
            end else if (mac_vld) begin
                acc <= acc_sum;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        y_addr    <= '0;
                        w_addr    <= '0;
                        sat_count <= '0;
                        for (int k = 0; k < N_S; k++) err_mem[k] <= '0;
                    end
                end
                ERR: begin
                    if (cnt < CNT_PRE) y_addr <= y_addr + CW'(1);
                    if (cnt == CNT_LAST) x_addr <= '0;
                end
                GRAD: begin
                    if (cnt < CNT_PRE) x_addr <= x_addr + XAW'(N_IN);
                end
                DRAIN: begin
                    w_wdata <= w_sat;
                    if (w_clamp) sat_count <= sat_count + (AW+1)'(1);
                end
                UPD: begin
                    if (w_addr != I_LAST) begin
                        w_addr <= w_addr + AW'(1);
                        x_addr <= XAW'(w_addr) + XAW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
